// File: rtl/branch_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// branch_issue_queue_pkg
// Shared definitions for the branch issue queue and the branch execution unit:
//   - ALU_JAL / ALU_JALR : alu_op encodings of the two jump micro-ops
//   - BIQ_DATA_WIDTH / BIQ_ROB_WIDTH : field widths of a queue entry
//   - branch_iq_entry_t  : one queue entry (valid, op, pc, imm, rob tag and
//                          ready/value/tag for each source operand)
// -----------------------------------------------------------------------------
package branch_issue_queue_pkg;

  localparam logic [3:0] ALU_JAL  = 4'b1100;
  localparam logic [3:0] ALU_JALR = 4'b1101;

  localparam int BIQ_DATA_WIDTH = 32;
  localparam int BIQ_ROB_WIDTH  = 4;

  typedef struct packed {
    logic                      valid;
    logic [3:0]                alu_op;
    logic [BIQ_DATA_WIDTH-1:0] pc;
    logic [BIQ_DATA_WIDTH-1:0] imm;
    logic [BIQ_ROB_WIDTH-1:0]  rob_tag;
    logic                      op1_rdy;
    logic [BIQ_DATA_WIDTH-1:0] op1_val;
    logic [BIQ_ROB_WIDTH-1:0]  op1_tag;
    logic                      op2_rdy;
    logic [BIQ_DATA_WIDTH-1:0] op2_val;
    logic [BIQ_ROB_WIDTH-1:0]  op2_tag;
  } branch_iq_entry_t;

endpackage : branch_issue_queue_pkg

// File: rtl/branch_issue_queue.sv
// -----------------------------------------------------------------------------
// branch_issue_queue
// In-order issue queue in front of the branch unit. Entries are dispatched at
// the tail, wait for their source operands on the CDB, and the head issues once
// both operands are ready. A flush empties the queue in one cycle.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_flush               drop every queued entry (mispredict recovery)
//   i_disp_*              dispatch request and entry fields, o_disp_ready back
//   i_cdb_valid/tag/data  common data bus broadcast used for operand wakeup
//   o_issue_valid         head entry issues this cycle (branch unit never stalls)
//   o_op1..o_rob_tag      fields of the head entry, straight from its registers
//
// Entry fields use the package widths, so DATA_WIDTH/ROB_WIDTH must stay equal
// to BIQ_DATA_WIDTH/BIQ_ROB_WIDTH. DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module branch_issue_queue
  import branch_issue_queue_pkg::*;
#(
  parameter int DATA_WIDTH = BIQ_DATA_WIDTH,
  parameter int ROB_WIDTH  = BIQ_ROB_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_disp_valid,
  output logic                  o_disp_ready,
  input  logic [3:0]            i_disp_alu_op,
  input  logic [DATA_WIDTH-1:0] i_disp_pc,
  input  logic [DATA_WIDTH-1:0] i_disp_imm,
  input  logic [ROB_WIDTH-1:0]  i_disp_rob_tag,
  input  logic                  i_disp_op1_rdy,
  input  logic                  i_disp_op2_rdy,
  input  logic [DATA_WIDTH-1:0] i_disp_op1_val,
  input  logic [DATA_WIDTH-1:0] i_disp_op2_val,
  input  logic [ROB_WIDTH-1:0]  i_disp_op1_tag,
  input  logic [ROB_WIDTH-1:0]  i_disp_op2_tag,
  input  logic                  i_cdb_valid,
  input  logic [ROB_WIDTH-1:0]  i_cdb_tag,
  input  logic [DATA_WIDTH-1:0] i_cdb_data,
  output logic                  o_issue_valid,
  output logic [DATA_WIDTH-1:0] o_op1,
  output logic [DATA_WIDTH-1:0] o_op2,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_imm,
  output logic [3:0]            o_alu_op,
  output logic [ROB_WIDTH-1:0]  o_rob_tag
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  branch_iq_entry_t entries_r   [DEPTH];
  branch_iq_entry_t entry_nxt_s [DEPTH];
  branch_iq_entry_t new_entry_s;
  branch_iq_entry_t head_entry_s;

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;

  logic             disp_ready_s;
  logic             accept_s;
  logic             issue_s;
  logic [DEPTH-1:0] wake1_s;
  logic [DEPTH-1:0] wake2_s;

  // Ready/issue decisions use registered state only (plus flush for issue).
  assign disp_ready_s = (count_r != FULL_COUNT);
  assign accept_s     = i_disp_valid && disp_ready_s;
  assign head_entry_s = entries_r[head_r];
  assign issue_s      = head_entry_s.valid && head_entry_s.op1_rdy &&
                        head_entry_s.op2_rdy && !i_flush;

  // Per-entry CDB tag comparators for both source operands.
  for (genvar g = 0; g < DEPTH; g++) begin : g_wakeup
    assign wake1_s[g] = i_cdb_valid && entries_r[g].valid && !entries_r[g].op1_rdy &&
                        (entries_r[g].op1_tag == i_cdb_tag);
    assign wake2_s[g] = i_cdb_valid && entries_r[g].valid && !entries_r[g].op2_rdy &&
                        (entries_r[g].op2_tag == i_cdb_tag);
  end

  // Build the entry being dispatched, capturing a same-cycle CDB result.
  always_comb begin
    new_entry_s         = '0;
    new_entry_s.valid   = 1'b1;
    new_entry_s.alu_op  = i_disp_alu_op;
    new_entry_s.pc      = i_disp_pc;
    new_entry_s.imm     = i_disp_imm;
    new_entry_s.rob_tag = i_disp_rob_tag;
    new_entry_s.op1_tag = i_disp_op1_tag;
    new_entry_s.op2_tag = i_disp_op2_tag;
    if (i_disp_op1_rdy) begin
      new_entry_s.op1_rdy = 1'b1;
      new_entry_s.op1_val = i_disp_op1_val;
    end else if (i_cdb_valid && (i_cdb_tag == i_disp_op1_tag)) begin
      new_entry_s.op1_rdy = 1'b1;
      new_entry_s.op1_val = i_cdb_data;
    end else begin
      new_entry_s.op1_rdy = 1'b0;
      new_entry_s.op1_val = '0;
    end
    if (i_disp_op2_rdy) begin
      new_entry_s.op2_rdy = 1'b1;
      new_entry_s.op2_val = i_disp_op2_val;
    end else if (i_cdb_valid && (i_cdb_tag == i_disp_op2_tag)) begin
      new_entry_s.op2_rdy = 1'b1;
      new_entry_s.op2_val = i_cdb_data;
    end else begin
      new_entry_s.op2_rdy = 1'b0;
      new_entry_s.op2_val = '0;
    end
  end

  // Next value of every entry: wakeup, head retirement on issue, tail write.
  // The tail slot is never the issuing head: accept implies not full, and an
  // empty queue has an invalid head.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_nxt_s[i] = entries_r[i];
      if (wake1_s[i]) begin
        entry_nxt_s[i].op1_rdy = 1'b1;
        entry_nxt_s[i].op1_val = i_cdb_data;
      end else begin
        entry_nxt_s[i].op1_rdy = entries_r[i].op1_rdy;
      end
      if (wake2_s[i]) begin
        entry_nxt_s[i].op2_rdy = 1'b1;
        entry_nxt_s[i].op2_val = i_cdb_data;
      end else begin
        entry_nxt_s[i].op2_rdy = entries_r[i].op2_rdy;
      end
      if (issue_s && (head_r == PTR_W'(i))) begin
        entry_nxt_s[i].valid = 1'b0;
      end else begin
        entry_nxt_s[i].valid = entries_r[i].valid;
      end
      if (accept_s && (tail_r == PTR_W'(i))) begin
        entry_nxt_s[i] = new_entry_s;
      end else begin
        entry_nxt_s[i] = entry_nxt_s[i];
      end
    end
  end

  // Entry storage; flush only drops valid bits so nothing stale can issue.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= entry_nxt_s[i];
      end
    end
  end

  // Head/tail pointers and occupancy count; pointers wrap on their own width.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (i_flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (issue_s) begin
        head_r <= head_r + PTR_ONE;
      end
      if (accept_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      case ({accept_s, issue_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign o_disp_ready  = disp_ready_s;
  assign o_issue_valid = issue_s;
  assign o_op1         = head_entry_s.op1_val;
  assign o_op2         = head_entry_s.op2_val;
  assign o_pc          = head_entry_s.pc;
  assign o_imm         = head_entry_s.imm;
  assign o_alu_op      = head_entry_s.alu_op;
  assign o_rob_tag     = head_entry_s.rob_tag;

endmodule : branch_issue_queue

// File: tb/tb_branch_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_issue_queue
// Directed scenarios followed by a randomized run. Expected outputs come from a
// queue-based model: a list of pending branches in program order, each with
// operand ready flags that are set by matching CDB broadcasts.
// -----------------------------------------------------------------------------
module tb_branch_issue_queue;

  localparam int DW    = 32;
  localparam int RW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          dv = 1'b0;
  logic [3:0]    aop = 4'd0;
  logic [DW-1:0] pc = '0, imm = '0, v1 = '0, v2 = '0, cdata = '0;
  logic [RW-1:0] rtag = '0, t1 = '0, t2 = '0, ctag = '0;
  logic          r1 = 1'b0, r2 = 1'b0, cv = 1'b0;

  logic          disp_ready, issue_valid;
  logic [DW-1:0] op1, op2, opc, oimm;
  logic [3:0]    oalu;
  logic [RW-1:0] orob;

  branch_issue_queue #(.DATA_WIDTH(DW), .ROB_WIDTH(RW), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_disp_valid(dv), .o_disp_ready(disp_ready),
    .i_disp_alu_op(aop), .i_disp_pc(pc), .i_disp_imm(imm), .i_disp_rob_tag(rtag),
    .i_disp_op1_rdy(r1), .i_disp_op2_rdy(r2),
    .i_disp_op1_val(v1), .i_disp_op2_val(v2),
    .i_disp_op1_tag(t1), .i_disp_op2_tag(t2),
    .i_cdb_valid(cv), .i_cdb_tag(ctag), .i_cdb_data(cdata),
    .o_issue_valid(issue_valid),
    .o_op1(op1), .o_op2(op2), .o_pc(opc), .o_imm(oimm),
    .o_alu_op(oalu), .o_rob_tag(orob)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] pc;
    logic [DW-1:0] imm;
    logic [RW-1:0] rob;
    logic          r1;
    logic [DW-1:0] v1;
    logic [RW-1:0] t1;
    logic          r2;
    logic [DW-1:0] v2;
    logic [RW-1:0] t2;
  } model_t;

  model_t mq[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flush = 1'b0; dv = 1'b0; cv = 1'b0;
    r1 = 1'b0; r2 = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op_i, input logic [DW-1:0] pc_i, input logic [DW-1:0] imm_i,
                      input logic [RW-1:0] rob_i,
                      input logic r1_i, input logic [DW-1:0] v1_i, input logic [RW-1:0] t1_i,
                      input logic r2_i, input logic [DW-1:0] v2_i, input logic [RW-1:0] t2_i);
    dv = 1'b1; aop = op_i; pc = pc_i; imm = imm_i; rtag = rob_i;
    r1 = r1_i; v1 = v1_i; t1 = t1_i; r2 = r2_i; v2 = v2_i; t2 = t2_i;
  endtask

  task automatic cdb(input logic [RW-1:0] tag_i, input logic [DW-1:0] data_i);
    cv = 1'b1; ctag = tag_i; cdata = data_i;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_issue"}, 32'(issue_valid), 32'd0);
    chk({name, "_ready"}, 32'(disp_ready), 32'd1);
    chk({name, "_op1"}, op1, 32'd0);
    chk({name, "_op2"}, op2, 32'd0);
    chk({name, "_pc"}, opc, 32'd0);
    chk({name, "_imm"}, oimm, 32'd0);
    chk({name, "_alu"}, 32'(oalu), 32'd0);
    chk({name, "_rob"}, 32'(orob), 32'd0);
  endtask

  // Compare outputs against the model for the current cycle, then advance the
  // model by what the coming rising edge does.
  task automatic check_and_model();
    model_t e;
    logic exp_ready, exp_issue, accept;
    exp_ready = (mq.size() < DEPTH);
    exp_issue = (mq.size() > 0) && mq[0].r1 && mq[0].r2 && !flush;
    chk("disp_ready", 32'(disp_ready), 32'(exp_ready));
    chk("issue_valid", 32'(issue_valid), 32'(exp_issue));
    if (exp_issue) begin
      chk("issue_op1", op1, mq[0].v1);
      chk("issue_op2", op2, mq[0].v2);
      chk("issue_pc", opc, mq[0].pc);
      chk("issue_imm", oimm, mq[0].imm);
      chk("issue_alu", 32'(oalu), 32'(mq[0].op));
      chk("issue_rob", 32'(orob), 32'(mq[0].rob));
    end
    if (flush) begin
      mq.delete();
    end else begin
      accept = dv && exp_ready;
      if (exp_issue) void'(mq.pop_front());
      foreach (mq[i]) begin
        if (cv && !mq[i].r1 && mq[i].t1 == ctag) begin mq[i].r1 = 1'b1; mq[i].v1 = cdata; end
        if (cv && !mq[i].r2 && mq[i].t2 == ctag) begin mq[i].r2 = 1'b1; mq[i].v2 = cdata; end
      end
      if (accept) begin
        e.op = aop; e.pc = pc; e.imm = imm; e.rob = rtag;
        e.r1 = r1 || (cv && ctag == t1); e.v1 = r1 ? v1 : cdata; e.t1 = t1;
        e.r2 = r2 || (cv && ctag == t2); e.v2 = r2 ? v2 : cdata; e.t2 = t2;
        mq.push_back(e);
      end
    end
  endtask

  task automatic tick();
    #1;
    check_and_model();
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    // Reset state
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single BEQ with both operands ready
    disp(4'b0000, 32'h100, 32'h20, 4'd1, 1'b1, 32'd5, 4'd0, 1'b1, 32'd5, 4'd0);
    tick();
    #1;
    chk("beq_issue", 32'(issue_valid), 32'd1);
    chk("beq_op1", op1, 32'd5);
    chk("beq_pc", opc, 32'h100);
    chk("beq_rob", 32'(orob), 32'd1);
    tick();
    tick();

    // BNE waiting on tag 3, held three cycles, then woken by the CDB
    disp(4'b0001, 32'h200, 32'h8, 4'd2, 1'b1, 32'h1, 4'd0, 1'b0, 32'h0, 4'd3);
    tick();
    tick(); tick(); tick();
    cdb(4'd3, 32'h7);
    tick();
    #1;
    chk("wake_issue", 32'(issue_valid), 32'd1);
    chk("wake_op2", op2, 32'h7);
    tick();

    // Same-cycle bypass
    disp(4'b0100, 32'h300, 32'h4, 4'd3, 1'b0, 32'h0, 4'd2, 1'b1, 32'h2, 4'd0);
    cdb(4'd2, 32'd9);
    tick();
    #1;
    chk("bypass_op1", op1, 32'd9);
    tick();

    // Non-ready head A ahead of ready B
    disp(4'b0101, 32'h400, 32'h0, 4'd4, 1'b0, 32'h0, 4'd5, 1'b1, 32'h3, 4'd0);
    tick();
    disp(4'b0110, 32'h404, 32'h0, 4'd5, 1'b1, 32'h6, 4'd0, 1'b1, 32'h6, 4'd0);
    tick();
    tick(); tick();
    cdb(4'd5, 32'h55);
    tick();
    tick();
    tick();

    // Fill to full, refused dispatch, issue-while-full, wrap of 8 entries
    disp(4'b0000, 32'h500, 32'h0, 4'd6, 1'b0, 32'h0, 4'd6, 1'b1, 32'h10, 4'd0);
    tick();
    for (int k = 1; k < 4; k++) begin
      disp(4'b0001, 32'h500 + 32'(k * 4), 32'(k), 4'(6 + k), 1'b1, 32'(k), 4'd0, 1'b1, 32'(k), 4'd0);
      tick();
    end
    #1;
    chk("full_ready", 32'(disp_ready), 32'd0);
    disp(4'b0111, 32'hDEAD, 32'h0, 4'd15, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0);
    tick();
    cdb(4'd6, 32'h66);
    tick();
    disp(4'b0111, 32'hBEEF, 32'h0, 4'd14, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      disp(4'b0010, 32'h600 + 32'(k * 4), 32'h0, 4'(10 + k), 1'b1, 32'(k + 20), 4'd0, 1'b1, 32'h1, 4'd0);
      tick();
    end
    for (int k = 0; k < 8; k++) tick();

    // Flush with three entries queued and a dispatch in the same cycle
    disp(4'b0000, 32'h700, 32'h0, 4'd1, 1'b0, 32'h0, 4'd7, 1'b1, 32'h1, 4'd0);
    tick();
    disp(4'b0000, 32'h704, 32'h0, 4'd2, 1'b1, 32'h1, 4'd0, 1'b1, 32'h1, 4'd0);
    tick();
    disp(4'b0000, 32'h708, 32'h0, 4'd3, 1'b1, 32'h1, 4'd0, 1'b1, 32'h1, 4'd0);
    tick();
    flush = 1'b1;
    disp(4'b0000, 32'h70C, 32'h0, 4'd4, 1'b1, 32'h1, 4'd0, 1'b1, 32'h1, 4'd0);
    tick();
    #1;
    chk("flush_ready", 32'(disp_ready), 32'd1);
    chk("flush_issue", 32'(issue_valid), 32'd0);
    cdb(4'd7, 32'h77);
    tick();
    tick(); tick();

    // Asynchronous reset in the middle of a cycle with two entries queued
    disp(4'b1100, 32'h800, 32'h44, 4'd8, 1'b0, 32'h0, 4'd8, 1'b1, 32'h1, 4'd0);
    tick();
    disp(4'b1101, 32'h804, 32'h48, 4'd9, 1'b0, 32'h0, 4'd8, 1'b1, 32'h1, 4'd0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    cdb(4'd8, 32'h88);
    tick();
    tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) < 6) begin
        disp(4'($urandom_range(0, 15)), $urandom, $urandom, 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 1) == 1) cdb(4'($urandom_range(0, 3)), $urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_branch_issue_queue
